// File: rtl/design_reset_ctrl_pkg.sv
// reset_ctrl_pkg: shared state encoding and default sizing for the per-design reset controller
package reset_ctrl_pkg;
  typedef enum logic [1:0] {RST_ASSERT, RST_SYNC, RST_HOLD, RST_RUN} rst_state_t;
  localparam int DEF_NUM_DESIGNS = 12;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD_CYCLES = 16;
endpackage

// File: rtl/design_reset_ctrl_channel.sv
// reset_channel: async-assert / sync-release reset sequencer with hold stretch and software reset
module reset_channel
  import reset_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic n_rst,
  input  logic sw_rst_req,
  output logic design_n_rst,
  output logic released
);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  rst_state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic n_rst_q, n_rst_d, rel_q, rel_d;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= RST_ASSERT;
      sync_q  <= '0;
      cnt_q   <= '0;
      n_rst_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      n_rst_q <= n_rst_d;
      rel_q   <= rel_d;
    end
  end
  // a request in HOLD always reloads, so a request on the release edge suppresses the release
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sync_d  = {sync_q[SYNC_STAGES-2:0], 1'b1};
    unique case (state_q)
      RST_ASSERT: state_d = RST_SYNC;
      RST_SYNC: begin
        state_d = sync_q[SYNC_STAGES-1] ? RST_HOLD : RST_SYNC;
        cnt_d   = sync_q[SYNC_STAGES-1] ? CNT_LOAD : cnt_q;
      end
      RST_HOLD: begin
        state_d = (!sw_rst_req && cnt_q == '0) ? RST_RUN : RST_HOLD;
        cnt_d   = sw_rst_req ? CNT_LOAD : (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
      end
      RST_RUN: begin
        state_d = sw_rst_req ? RST_HOLD : RST_RUN;
        cnt_d   = sw_rst_req ? CNT_LOAD : cnt_q;
      end
    endcase
  end
  always_comb begin
    n_rst_d = state_d == RST_RUN;
    rel_d   = state_q == RST_HOLD && state_d == RST_RUN;
  end
  assign design_n_rst = n_rst_q;
  assign released     = rel_q;
endmodule

// File: rtl/design_reset_ctrl.sv
// design_reset_ctrl: one independent reset sequencer per hosted design, gated by its enable
module design_reset_ctrl
  import reset_ctrl_pkg::*;
#(
  parameter int NUM_DESIGNS = DEF_NUM_DESIGNS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [NUM_DESIGNS:1]   designs_en,
  input  logic [NUM_DESIGNS:1]   sw_rst_req,
  output logic [NUM_DESIGNS:1]   designs_n_rst,
  output logic [NUM_DESIGNS:1]   designs_released
);
  logic [NUM_DESIGNS:1] chan_n_rst;
  assign chan_n_rst = {NUM_DESIGNS{n_rst}} & designs_en;
  for (genvar i = 1; i <= NUM_DESIGNS; i++) begin : g_chan
    reset_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_chan (
      .clk         (clk),
      .n_rst       (chan_n_rst[i]),
      .sw_rst_req  (sw_rst_req[i]),
      .design_n_rst(designs_n_rst[i]),
      .released    (designs_released[i])
    );
  end
endmodule

// File: tb/tb_design_reset_ctrl.sv
// tb_design_reset_ctrl: directed checks of release latency, disable, software reset and a small parameter set
module tb_design_reset_ctrl;
  logic clk = 1'b0;
  logic n_rst, n_rst2;
  logic [12:1] en, sw, out, rel;
  logic [2:1] en2, sw2, out2, rel2;
  int n_chk = 0, n_pass = 0;
  localparam logic [31:0] ALL = 32'hFFF;
  always #5 clk = ~clk;
  design_reset_ctrl dut (
    .clk(clk), .n_rst(n_rst), .designs_en(en), .sw_rst_req(sw),
    .designs_n_rst(out), .designs_released(rel)
  );
  design_reset_ctrl #(.NUM_DESIGNS(2), .SYNC_STAGES(3), .HOLD_CYCLES(1)) dut2 (
    .clk(clk), .n_rst(n_rst2), .designs_en(en2), .sw_rst_req(sw2),
    .designs_n_rst(out2), .designs_released(rel2)
  );
  function automatic logic [31:0] bit_of(input int ch);
    return 32'(1) << (ch - 1);
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_rise(input string tag, input bit alt, input int ch, input int exp_edge,
                           input logic [31:0] exp_out, input logic [31:0] exp_rel);
    int e;
    logic [31:0] o;
    e = 0;
    o = '0;
    for (int i = 1; i <= exp_edge + 4 && e == 0; i++) begin
      step();
      o = alt ? 32'(out2) : 32'(out);
      if (o[ch-1]) e = i;
    end
    check({tag, "_edge"}, e, exp_edge);
    check({tag, "_out"}, o, exp_out);
    check({tag, "_rel"}, alt ? 32'(rel2) : 32'(rel), exp_rel);
    step();
    check({tag, "_pulse_end"}, alt ? 32'(rel2) : 32'(rel), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    n_rst = 1'b0; en = '1; sw = '0;
    n_rst2 = 1'b0; en2 = '1; sw2 = '0;
    repeat (3) step();
    check("reset_out", out, 0);
    check("reset_rel", rel, 0);
    n_rst = 1'b1;
    wait_rise("powerup", 1'b0, 1, 19, ALL, ALL);
    en[5] = 1'b0;
    #1;
    check("dis_async", out, ALL & ~bit_of(5));
    repeat (3) step();
    check("dis_others", out, ALL & ~bit_of(5));
    check("dis_rel", rel, 0);
    en[5] = 1'b1;
    wait_rise("reenable", 1'b0, 5, 19, ALL, bit_of(5));
    sw[3] = 1'b1;
    step();
    sw[3] = 1'b0;
    check("sw_low", out, ALL & ~bit_of(3));
    wait_rise("sw3", 1'b0, 3, 16, ALL, bit_of(3));
    sw[7] = 1'b1;
    step();
    sw[7] = 1'b0;
    repeat (10) step();
    check("ext_mid_out", out, ALL & ~bit_of(7));
    sw[7] = 1'b1;
    step();
    sw[7] = 1'b0;
    check("ext_mid_rel", rel, 0);
    wait_rise("ext7", 1'b0, 7, 16, ALL, bit_of(7));
    sw[2] = 1'b1;
    repeat (20) step();
    check("held_out", out, ALL & ~bit_of(2));
    step();
    sw[2] = 1'b0;
    wait_rise("held2", 1'b0, 2, 16, ALL, bit_of(2));
    n_rst = 1'b0;
    #1;
    check("async_run", out, 0);
    n_rst = 1'b1;
    repeat (2) step();
    n_rst = 1'b0;
    #1;
    check("async_sync_out", out, 0);
    check("async_sync_rel", rel, 0);
    n_rst = 1'b1;
    wait_rise("after_sync", 1'b0, 1, 19, ALL, ALL);
    n_rst = 1'b0;
    #1;
    n_rst = 1'b1;
    repeat (8) step();
    n_rst = 1'b0;
    #1;
    check("async_hold_out", out, 0);
    n_rst = 1'b1;
    wait_rise("after_hold", 1'b0, 1, 19, ALL, ALL);
    n_rst2 = 1'b1;
    wait_rise("p_powerup", 1'b1, 1, 5, 32'h3, 32'h3);
    sw2[1] = 1'b1;
    step();
    sw2[1] = 1'b0;
    check("p_sw_low", 32'(out2), 32'h2);
    wait_rise("p_sw", 1'b1, 1, 1, 32'h3, 32'h1);
    check("p_main_steady", out, ALL);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
